// File: rtl/uart_pkg.sv
// uart_pkg: encodings and defaults shared by the UART TX FSM, the TX datapath
// and the RX parity checker.
//   mux_sel_e          - line-select encoding driven by the TX FSM
//   PAR_EVEN / PAR_ODD - parity_type encodings
//   DEFAULT_DATA_W     - default data word width
package uart_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;
  localparam int unsigned MUX_W          = 2;

  typedef enum logic [MUX_W-1:0] {
    MUX_STOP  = 2'b00,
    MUX_START = 2'b01,
    MUX_DATA  = 2'b10,
    MUX_PAR   = 2'b11
  } mux_sel_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_tx_datapath_if.sv
// uart_tx_datapath_if: link between the UART TX control FSM and its datapath.
//   data_in/valid/parity_en/parity_type - word offer from the host side
//   busy/ser_en/mux_sel                 - FSM controls
//   ser_done                            - datapath -> FSM, last data bit now
//   tx_out                              - registered serial line
// master: FSM/host side, slave: datapath side.
interface uart_tx_datapath_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) ();

  logic [DATA_W-1:0] data_in;
  logic              valid;
  logic              parity_en;
  logic              parity_type;
  logic              busy;
  logic              ser_en;
  mux_sel_e          mux_sel;
  logic              ser_done;
  logic              tx_out;

  modport master (
    output data_in, valid, parity_en, parity_type, busy, ser_en, mux_sel,
    input  ser_done, tx_out
  );

  modport slave (
    input  data_in, valid, parity_en, parity_type, busy, ser_en, mux_sel,
    output ser_done, tx_out
  );

endinterface : uart_tx_datapath_if

// File: rtl/uart_parity_calc.sv
// uart_parity_calc: combinational parity over DATA_W bits, shared by TX and RX.
//   data        - word to protect
//   parity_type - PAR_EVEN / PAR_ODD
//   parity_c    - parity bit making the total number of ones even/odd
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] data,
  input  logic              parity_type,
  output logic              parity_c
);

  assign parity_c = (parity_type == PAR_ODD) ? ~^data : ^data;

endmodule : uart_parity_calc

// File: rtl/uart_tx_datapath.sv
// uart_tx_datapath: byte capture, LSB-first serializer, parity and registered
// line mux for the UART transmitter. One bit per clk.
//   clk - system clock, rising edge
//   rst - synchronous active-low reset
//   bus - uart_tx_datapath_if.slave (FSM controls in, ser_done/tx_out out)
module uart_tx_datapath
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input logic               clk,
  input logic               rst,
  uart_tx_datapath_if.slave bus
);

  localparam int unsigned     CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              parity_bit;
  logic              tx_q;

  logic              load_en_c;
  logic              last_bit_c;
  logic              parity_c;
  logic              line_c;

  // parity_en and busy are consumed by the FSM only
  logic unused_fsm_flags;
  assign unused_fsm_flags = bus.parity_en ^ bus.busy;

  // Stop and idle share MUX_STOP, so back-to-back words load during stop
  assign load_en_c  = bus.valid && (bus.mux_sel == MUX_STOP) && !bus.ser_en;
  assign last_bit_c = (bit_cnt == CNT_LAST);

  uart_parity_calc #(
    .DATA_W (DATA_W)
  ) u_parity (
    .data        (bus.data_in),
    .parity_type (bus.parity_type),
    .parity_c    (parity_c)
  );

  // Line select for the next registered tx_out value
  always_comb begin
    line_c = 1'b1;
    case (bus.mux_sel)
      MUX_STOP:  line_c = 1'b1;
      MUX_START: line_c = 1'b0;
      MUX_DATA:  line_c = shift_reg[0];
      MUX_PAR:   line_c = parity_bit;
      default:   line_c = 1'b1;
    endcase
  end

  // Capture, shift, bit count and registered line
  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      if (load_en_c) begin
        shift_reg  <= bus.data_in;
        parity_bit <= parity_c;
      end else if (bus.ser_en) begin
        shift_reg  <= shift_reg >> 1;
      end

      // Counter only runs across a contiguous ser_en burst
      if (bus.ser_en) begin
        bit_cnt <= last_bit_c ? '0 : bit_cnt + CNT_W'(1);
      end else begin
        bit_cnt <= '0;
      end

      tx_q <= line_c;
    end
  end

  assign bus.ser_done = bus.ser_en && last_bit_c;
  assign bus.tx_out   = tx_q;

endmodule : uart_tx_datapath

// File: doc/uart_tx_datapath.md
Name: uart_tx_datapath

Overview:
- Datapath partner of the UART transmit control FSM, sitting directly downstream of it.
- Consumes the FSM's `ser_en`, `mux_sel` and `busy`, and returns `ser_done` to it.
- Captures the byte, serializes it LSB-first, computes parity, and drives the registered serial line `tx_out`.
- Timing is one bit per `clk` cycle; any baud prescaling happens outside this block.

Parameters:
- DATA_W, 8, data word width in bits; the bit counter width is clog2(DATA_W).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- data_in  input  DATA_W  parallel word to transmit.
- valid  input  1  word on `data_in` is offered for transmission.
- parity_en  input  1  parity bit is sent (used by the FSM; not used here).
- parity_type  input  1  0 = even parity, 1 = odd parity; sampled at load.
- busy  input  1  FSM busy flag (not used for load decision).
- ser_en  input  1  FSM data-state strobe; shift one bit per cycle.
- mux_sel  input  2  line select: 00 = idle/stop (1), 01 = start (0), 10 = data bit, 11 = parity bit.
- ser_done  output  1  last data bit is on the serializer this cycle.
- tx_out  output  1  serial UART line.

Behaviour:
- Reset (rst=0 at a clk edge) clears state as follows:
  - shift_reg=0, bit_cnt=0, parity_bit=0.
  - tx_out=1 (line idle).
  - ser_done=0, because it is gated by ser_en, which the FSM holds low in idle.
- Load: load_en = valid && mux_sel==2'b00 && !ser_en.
  - The condition covers both FSM idle and stop states, so back-to-back frames load during stop.
  - On load: shift_reg <= data_in; parity_bit <= parity_type ? ~^data_in : ^data_in.
  - `valid` in any other cycle is ignored; later changes on `data_in` never corrupt an in-flight frame.
- Serialize: on each edge with ser_en=1, shift_reg <= shift_reg >> 1 (zero fill).
  - bit_cnt increments and wraps to 0 when bit_cnt==DATA_W-1.
  - When ser_en=0, bit_cnt is held at 0.
  - Data bit presented this cycle = shift_reg[0].
- ser_done is combinational: ser_en && bit_cnt==DATA_W-1.
  - It is high only during the DATA_W-th consecutive ser_en cycle.
  - The FSM therefore spends exactly DATA_W cycles in the data state.
- Output mux, registered: tx_out <= f(mux_sel).
  - 00 selects 1, 01 selects 0, 10 selects shift_reg[0], 11 selects parity_bit.
  - tx_out lags mux_sel by exactly one clk; the frame shape is unchanged, only shifted by one cycle.
- ser_en dropping mid-word (illegal FSM behaviour): bit_cnt returns to 0 and shift_reg holds. No error flag; verification asserts this never occurs.
- Reset mid-frame: on the next edge all state returns to reset values, tx_out=1, and the partial frame is abandoned.
- valid and ser_en both high in the same cycle: ser_en wins, no load.

Decomposition:
- Shared package uart_pkg holds:
  - The mux_sel encodings: MUX_STOP=2'b00, MUX_START=2'b01, MUX_DATA=2'b10, MUX_PAR=2'b11.
  - The PAR_EVEN/PAR_ODD constants.
  - The DATA_W default.
  - These encodings are also used by the TX FSM.
- One natural sub-module, uart_parity_calc: a combinational parity of DATA_W bits plus type. This keeps it reusable for the RX checker.
- Serializer, counter and output mux stay in this module.

Test Plan:
- Even parity frame:
  - Stimulus: reset, then data_in=8'hA5, valid pulse, parity_type=0, FSM model driving start/8 data/parity/stop.
  - Response: tx_out sequence one cycle after mux_sel is 0,1,0,1,0,0,1,0,1,0,1.
  - ser_done high only on the 8th ser_en cycle.
- Odd parity: same as above with parity_type=1 → parity bit=1; all other bits identical.
- Parity disabled: data_in=8'h3C, parity_en=0 → tx_out is 0,0,0,1,1,1,1,0,0,1 (10-bit frame), with no mux_sel=11 cycle.
- Back-to-back frames: hold valid in the stop state with data_in=8'hF0 after an 8'h0F frame → the second frame's start bit follows the first frame's stop bit with no idle gap, and data bits 0,0,0,0,1,1,1,1.
- Ignored valid: valid and data_in=8'hFF asserted mid data state of an 8'h00 frame → all data bits 0 and even parity bit 0.
- Reset mid-frame: rst=0 after the 3rd data bit → next cycle tx_out=1 and ser_done=0; after release, a new 8'h81 frame transmits correctly.
